bist_engine: RTL
================

BIST_ENGINE -- requirements
Module: bist_engine

Interface
REQ-001 The block SHALL take parameter W, default 8, which is the scan chain width; W SHALL be even and at least 4.
REQ-002 The block SHALL take parameter NPAT, default 16, which is the number of test patterns per run; NPAT SHALL be at least 1.
REQ-003 The block SHALL take parameter SEED, default 8'b10111101, which is the LFSR reset and restart value; SEED SHALL be nonzero.
REQ-004 The block SHALL take parameter TAPS, default 8'b10001110, which is the feedback mask shared by the LFSR and the SISR.
REQ-005 Port clk: input, 1 bit, the single clock; every register SHALL update on its rising edge.
REQ-006 Port rst_n: input, 1 bit, reset; it SHALL be synchronous and active-low.
REQ-007 Port start: input, 1 bit, a one-cycle run request.
REQ-008 Port golden: input, W bits, the expected signature; it SHALL be sampled in the DONE state.
REQ-009 Port scan_in: output, 1 bit, the LFSR serial output, equal to lfsr[W-1].
REQ-010 Port scan_en: output, 1 bit, high during SHIFT and UNLOAD, low otherwise.
REQ-011 Port scan_out: output, 1 bit, equal to chain[0].
REQ-012 Port chain: output, W bits, the scan chain contents, provided for debug.
REQ-013 Port signature: output, W bits, the current SISR value.
REQ-014 Port busy: output, 1 bit, high in SHIFT, CAPTURE and UNLOAD.
REQ-015 Port done: output, 1 bit, high in the DONE state.
REQ-016 Port pass: output, 1 bit, equal to (signature == golden) while done is high, and 0 otherwise.

Function
REQ-017 The FSM SHALL have the states IDLE, SHIFT, CAPTURE, UNLOAD and DONE, with a bit counter over 0..W-1 and a pattern counter over 0..NPAT-1.
REQ-018 In IDLE or DONE, start=1 SHALL load lfsr=SEED, chain=0, sisr=0 and both counters to 0, then enter SHIFT.
REQ-019 In SHIFT, each cycle SHALL perform all of the following:
- chain <= {lfsr[W-1], chain[W-1:1]};
- lfsr <= {lfsr[W-2:0], ^(lfsr & TAPS)};
- the SISR SHALL be updated as in REQ-022;
- the bit counter SHALL increment.
REQ-020 After the W-th SHIFT cycle the FSM SHALL enter CAPTURE.
REQ-021 CAPTURE SHALL last exactly 1 cycle, and its behaviour SHALL be:
- chain <= chain[W-1:W/2] * chain[W/2-1:0], an unsigned product of exactly W bits with no overflow possible;
- the LFSR and SISR SHALL hold;
- the pattern counter SHALL increment;
- the next state SHALL be SHIFT if fewer than NPAT patterns have been captured, otherwise UNLOAD.
REQ-022 The SISR update SHALL be sisr <= {sisr[W-2:0], scan_out ^ (^(sisr & TAPS))}, and it SHALL run only in SHIFT and UNLOAD.
REQ-023 UNLOAD SHALL last W cycles, with chain <= {1'b0, chain[W-1:1]}, the SISR updating, and the LFSR holding; after it the FSM SHALL enter DONE.
REQ-024 Total run length from the start-sampling edge to done=1 SHALL be exactly NPAT*(W+1)+W cycles.
REQ-025 The first SHIFT phase SHALL compress the all-zero chain into the SISR, and this SHALL be part of the defined signature.
REQ-026 DONE SHALL hold signature, chain and lfsr until start or reset.
REQ-027 start while busy=1 SHALL be ignored, with no effect on state, counters or data.
REQ-028 The LFSR SHALL never reach all-zero when SEED is nonzero and TAPS is maximal-length; the default TAPS is maximal-length.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force state=IDLE, lfsr=SEED, chain=0, sisr=0 and both counters to 0.
REQ-030 During reset the outputs SHALL be busy=0, done=0, pass=0, scan_en=0, and scan_in=SEED[W-1].
REQ-031 Reset SHALL take priority over start and over any in-progress run; an aborted run SHALL leave no residual state.

Verification
REQ-032 Reset check: hold rst_n=0 for 2 cycles with default parameters -> chain=8'h00, signature=8'h00, scan_in=1, busy=0, done=0, pass=0.
REQ-033 First pattern: start for 1 cycle -> after 8 SHIFT cycles chain=8'hBD; after CAPTURE chain=8'h8F (11*13=143).
REQ-034 Full run: start, then count cycles -> done rises exactly 16*9+8=152 cycles after the start edge; signature matches the bench reference model; pass=1 with golden equal to that value; pass=0 with golden^8'h01.
REQ-035 Busy start: pulse start at cycles 5 and 50 of a run -> cycle count and signature are identical to the REQ-034 run.
REQ-036 Reset mid-run: assert rst_n=0 during the 3rd CAPTURE, then restart -> the REQ-034 signature and cycle count are reproduced exactly.
REQ-037 Parametrised run: W=16, NPAT=4, a 16-bit maximal SEED/TAPS, start -> done after 4*17+16=84 cycles; every CAPTURE product equals chain[15:8]*chain[7:0] and matches the reference model.

Source files
------------

// File: rtl/bist_engine.sv
// bist_engine: logic BIST controller built around one scan chain.
// An LFSR feeds pseudo-random patterns serially into the chain. After each full load,
// the chain captures the product of its upper and lower halves. The chain is then
// compressed into a SISR while the next pattern shifts in. After the last pattern,
// an unload phase flushes the chain through the SISR. The SISR value is then compared
// against `golden`.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      one-cycle run request; ignored while busy
//   golden     expected signature, compared in DONE
//   scan_in    LFSR serial output (lfsr[W-1])
//   scan_en    high in SHIFT and UNLOAD
//   scan_out   chain[0]
//   chain      scan chain contents (debug)
//   signature  current SISR value
//   busy       high in SHIFT, CAPTURE and UNLOAD
//   done       high in DONE
//   pass       (signature == golden) while done, else 0
module bist_engine #(
    parameter int unsigned  W    = 8,
    parameter int unsigned  NPAT = 16,
    parameter logic [W-1:0] SEED = 8'b10111101,
    parameter logic [W-1:0] TAPS = 8'b10001110
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] golden,
    output logic         scan_in,
    output logic         scan_en,
    output logic         scan_out,
    output logic [W-1:0] chain,
    output logic [W-1:0] signature,
    output logic         busy,
    output logic         done,
    output logic         pass
);

    localparam int unsigned BW = $clog2(W);
    localparam int unsigned PW = (NPAT > 1) ? $clog2(NPAT) : 1;
    localparam int unsigned HW = W / 2;

    typedef enum logic [2:0] {StIdle, StShift, StCapture, StUnload, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    lfsr_q, lfsr_d;
    logic [W-1:0]    chain_q, chain_d;
    logic [W-1:0]    sisr_q, sisr_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [PW-1:0]   pat_q, pat_d;

    logic [W-1:0]    sisr_step;
    logic [W-1:0]    product;
    logic            last_bit;
    logic            last_pat;

    // SISR absorbs the bit currently leaving the chain.
    assign sisr_step = {sisr_q[W-2:0], chain_q[0] ^ (^(sisr_q & TAPS))};
    // Both halves zero-extended to W bits; an HW x HW product always fits in W bits.
    assign product   = {{HW{1'b0}}, chain_q[W-1:HW]} * {{HW{1'b0}}, chain_q[HW-1:0]};
    assign last_bit  = (bit_q == BW'(W - 1));
    assign last_pat  = (pat_q == PW'(NPAT - 1));

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        chain_d = chain_q;
        sisr_d  = sisr_q;
        bit_d   = bit_q;
        pat_d   = pat_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StShift;
                    lfsr_d  = SEED;
                    chain_d = '0;
                    sisr_d  = '0;
                    bit_d   = '0;
                    pat_d   = '0;
                end
            end
            StShift: begin
                chain_d = {lfsr_q[W-1], chain_q[W-1:1]};
                lfsr_d  = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
                sisr_d  = sisr_step;
                if (last_bit) begin
                    bit_d   = '0;
                    state_d = StCapture;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            StCapture: begin
                chain_d = product;
                if (last_pat) begin
                    pat_d   = '0;
                    state_d = StUnload;
                end else begin
                    pat_d   = pat_q + PW'(1);
                    state_d = StShift;
                end
            end
            StUnload: begin
                chain_d = {1'b0, chain_q[W-1:1]};
                sisr_d  = sisr_step;
                if (last_bit) begin
                    bit_d   = '0;
                    state_d = StDone;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            chain_q <= '0;
            sisr_q  <= '0;
            bit_q   <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            chain_q <= chain_d;
            sisr_q  <= sisr_d;
            bit_q   <= bit_d;
            pat_q   <= pat_d;
        end
    end

    assign scan_in   = lfsr_q[W-1];
    assign scan_out  = chain_q[0];
    assign chain     = chain_q;
    assign signature = sisr_q;
    assign scan_en   = (state_q == StShift) || (state_q == StUnload);
    assign busy      = (state_q == StShift) || (state_q == StCapture) || (state_q == StUnload);
    assign done      = (state_q == StDone);
    assign pass      = done && (sisr_q == golden);

endmodule
